// File: rtl/des_ctrl_pkg.sv
// Shared definitions for the DES round sequencer: state encoding, round count
// and the encrypt key-schedule rotation table.
package des_ctrl_pkg;

    localparam int NUM_ROUNDS_DEF = 16;

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_LOAD       = 3'd1,
        ST_ROUND      = 3'd2,
        ST_ROUND_WAIT = 3'd3,
        ST_FINAL      = 3'd4,
        ST_DONE       = 3'd5
    } state_t;

    // Entry for round r sits at bits [2r-1:2r-2]; round 16 is the top entry.
    localparam logic [31:0] ENC_SHIFT_TBL = {
        2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd1,
        2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd1, 2'd1
    };

    // Decrypt walks the schedule backwards: no rotation before round 1,
    // then the encrypt amounts of rounds 2..16 in the same positions.
    function automatic logic [1:0] key_shift_for(input logic [4:0] rnd,
                                                 input logic       decrypt);
        logic [1:0] sh;
        logic [3:0] idx;
        sh  = 2'd0;
        idx = rnd[3:0] - 4'd1;
        if (rnd != 5'd0 && rnd <= 5'd16)
            sh = ENC_SHIFT_TBL[{idx, 1'b0} +: 2];
        if (decrypt && rnd == 5'd1)
            sh = 2'd0;
        return sh;
    endfunction

endpackage

// File: rtl/btn_fall_detect.sv
// Registered falling-edge detector for an active-low pushbutton.
module btn_fall_detect (
    input  logic clk,
    input  logic rst,
    input  logic btn,
    output logic fall
);

    logic btn_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            btn_q <= 1'b1;
        else
            btn_q <= btn;
    end

    assign fall = btn_q & ~btn;

endmodule

// File: rtl/des_round_controller.sv
// Sequencing FSM for the iterative DES datapath (load, 16 rounds, final perm).
// Build option: define ROUND_STEP_EN to single-step rounds with the step button.
module des_round_controller
    import des_ctrl_pkg::*;
#(
    parameter int NUM_ROUNDS = NUM_ROUNDS_DEF
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       clear,
    input  logic       step,
    input  logic       mode,
    input  logic       data_ready,
    input  logic       key_ready,
    output logic       dp_load,
    output logic       dp_round_en,
    output logic       dp_final,
    output logic [1:0] key_shift,
    output logic       key_dir,
    output logic [4:0] round,
    output logic       busy,
    output logic       done,
    output logic       err,
    output logic [2:0] S
);

    localparam logic [4:0] LAST_ROUND = 5'(NUM_ROUNDS);

    state_t     state, state_nx;
    logic [4:0] round_q, round_nx;
    logic       mode_q, mode_nx;
    logic       err_q, err_nx;
    logic       start_fall, step_fall;
    logic       both_ready;

    btn_fall_detect u_start_fall (
        .clk  (clk),
        .rst  (rst),
        .btn  (start),
        .fall (start_fall)
    );

    btn_fall_detect u_step_fall (
        .clk  (clk),
        .rst  (rst),
        .btn  (step),
        .fall (step_fall)
    );

`ifndef ROUND_STEP_EN
    logic unused_step_fall;
    assign unused_step_fall = step_fall;
`endif

    assign both_ready = data_ready & key_ready;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= ST_IDLE;
            round_q <= 5'd0;
            mode_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state   <= state_nx;
            round_q <= round_nx;
            mode_q  <= mode_nx;
            err_q   <= err_nx;
        end
    end

    always_comb begin
        state_nx = state;
        round_nx = round_q;
        mode_nx  = mode_q;
        err_nx   = err_q;
        if (!clear) begin
            state_nx = ST_IDLE;
            round_nx = 5'd0;
            err_nx   = 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start_fall) begin
                        if (both_ready) begin
                            state_nx = ST_LOAD;
                            err_nx   = 1'b0;
                        end else begin
                            err_nx   = 1'b1;
                        end
                    end
                end
                ST_LOAD: begin
                    mode_nx  = mode;
                    round_nx = 5'd1;
                    state_nx = ST_ROUND;
                end
                ST_ROUND: begin
                    if (round_q == LAST_ROUND) begin
                        state_nx = ST_FINAL;
                    end else begin
`ifdef ROUND_STEP_EN
                        state_nx = ST_ROUND_WAIT;
`else
                        round_nx = round_q + 5'd1;
`endif
                    end
                end
                ST_ROUND_WAIT: begin
`ifdef ROUND_STEP_EN
                    if (step_fall) begin
                        round_nx = round_q + 5'd1;
                        state_nx = ST_ROUND;
                    end
`else
                    state_nx = ST_IDLE;
                    round_nx = 5'd0;
`endif
                end
                ST_FINAL: state_nx = ST_DONE;
                ST_DONE: begin
                    // Restart keeps the sticky error; only IDLE clears it.
                    if (start_fall) begin
                        if (both_ready)
                            state_nx = ST_LOAD;
                        else
                            err_nx = 1'b1;
                    end
                end
                default: begin
                    state_nx = ST_IDLE;
                    round_nx = 5'd0;
                end
            endcase
        end
    end

    // Datapath strobes are suppressed while clear is held so an abort never
    // lets a half-finished round or final permutation reach the registers.
    assign dp_load     = (state == ST_LOAD)  & clear;
    assign dp_round_en = (state == ST_ROUND) & clear;
    assign dp_final    = (state == ST_FINAL) & clear;

    assign busy = (state == ST_LOAD) || (state == ST_ROUND) ||
                  (state == ST_ROUND_WAIT) || (state == ST_FINAL);
    assign done = (state == ST_DONE);

    assign key_shift = (state == ST_ROUND) ? key_shift_for(round_q, mode_q) : 2'd0;
    assign key_dir   = mode_q;
    assign round     = round_q;
    assign err       = err_q;
    assign S         = state;

endmodule

// File: tb/tb_des_round_controller.sv
// Self-checking bench for des_round_controller: cycle-accurate run model plus
// directed runs pinned to hand-computed key schedules.
module tb_des_round_controller;

`ifdef ROUND_STEP_EN
    localparam bit STEP_MODE = 1'b1;
`else
    localparam bit STEP_MODE = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst, start, clear, step, mode, data_ready, key_ready;
    logic       dp_load, dp_round_en, dp_final, key_dir, busy, done, err;
    logic [1:0] key_shift;
    logic [4:0] round;
    logic [2:0] S;

    int errors = 0;
    int checks = 0;

    des_round_controller dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .clear       (clear),
        .step        (step),
        .mode        (mode),
        .data_ready  (data_ready),
        .key_ready   (key_ready),
        .dp_load     (dp_load),
        .dp_round_en (dp_round_en),
        .dp_final    (dp_final),
        .key_shift   (key_shift),
        .key_dir     (key_dir),
        .round       (round),
        .busy        (busy),
        .done        (done),
        .err         (err),
        .S           (S)
    );

    always #5 clk = ~clk;

    int enc_tbl[16] = '{1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};
    int dec_tbl[16] = '{0, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Rotation amount straight from the DES schedule rules.
    function automatic int shift_of(input int r, input bit dec);
        if (dec && r == 1) return 0;
        if (r == 1 || r == 2 || r == 9 || r == 16) return 1;
        return 2;
    endfunction

    // Run model: pos = -1 outside a run, 0 = load, 1..16 = round, 17 = final.
    int pos, m_round;
    bit m_done, m_err, m_mode, m_wait, p_start, p_step;

    task automatic model_reset();
        pos = -1; m_round = 0; m_done = 0; m_err = 0; m_mode = 0; m_wait = 0;
        p_start = 1; p_step = 1;
    endtask

    initial begin
        bit sf, tf, rdy;
        model_reset();
        forever begin
            @(posedge clk or negedge rst);
            if (!rst) begin
                model_reset();
            end else begin
                sf = p_start & ~start;
                tf = p_step & ~step;
                p_start = start;
                p_step  = step;
                rdy = data_ready & key_ready;
                if (!clear) begin
                    pos = -1; m_done = 0; m_err = 0; m_wait = 0; m_round = 0;
                end else if (pos < 0) begin
                    if (sf) begin
                        if (rdy) begin
                            if (!m_done) m_err = 0;
                            m_done = 0;
                            pos = 0;
                        end else begin
                            m_err = 1;
                        end
                    end
                end else if (pos == 0) begin
                    m_mode = mode; m_round = 1; pos = 1;
                end else if (pos <= 16) begin
                    if (m_wait) begin
                        if (tf) begin m_wait = 0; pos++; m_round = pos; end
                    end else if (pos == 16) pos = 17;
                    else if (STEP_MODE) m_wait = 1;
                    else begin pos++; m_round = pos; end
                end else begin
                    pos = -1; m_done = 1;
                end
            end
        end
    end

    // Cycle-by-cycle comparison of every output against the run model.
    initial begin
        logic [16:0] expv, actv;
        int es, ks;
        bit in_rnd;
        forever begin
            @(negedge clk);
            in_rnd = (pos >= 1 && pos <= 16 && !m_wait);
            es = (pos < 0) ? (m_done ? 5 : 0) : (pos == 0) ? 1 : (pos <= 16) ? (m_wait ? 3 : 2) : 4;
            ks = in_rnd ? shift_of(pos, m_mode) : 0;
            expv = {3'(es), 5'(m_round), 2'(ks), m_mode, (pos >= 0), m_done, m_err,
                    (pos == 0) & clear, in_rnd & clear, (pos == 17) & clear};
            actv = {S, round, key_shift, key_dir, busy, done, err, dp_load, dp_round_en, dp_final};
            checks++;
            if (actv !== expv) begin
                errors++;
                $display("FAIL outputs: got %05h, expected %05h (S,round,shift,dir,busy,done,err,load,rnd,fin) at %0t",
                         actv, expv, $time);
            end
        end
    end

    int load_cnt = 0, final_cnt = 0;
    initial forever begin
        @(negedge clk);
        if (dp_load)  load_cnt++;
        if (dp_final) final_cnt++;
    end

    // Step button driver: presses after step_delay cycles in ROUND_WAIT, or random noise.
    bit step_noise = 0;
    int step_delay = 100;
    initial begin
        int wait_cnt = 0;
        step = 1;
        forever begin
            @(posedge clk); #1;
            if (step_noise) step = 1'($urandom_range(0, 1));
            else if (step == 1'b0) step = 1;
            else if (S == 3'd3) begin
                if (wait_cnt >= step_delay) begin step = 0; wait_cnt = 0; end
                else wait_cnt++;
            end else wait_cnt = 0;
        end
    end

    task automatic press_start();
        @(posedge clk); #1 start = 0;
        @(posedge clk); #1 start = 1;
    endtask

    int cap_shift[$], cap_round[$];
    int busy_n, last_pulse, done_at;

    task automatic capture_run(input bit toggle);
        cap_shift.delete(); cap_round.delete();
        busy_n = 0; last_pulse = -1; done_at = -1;
        for (int c = 0; c < 4000 && done_at < 0; c++) begin
            @(negedge clk);
            if (dp_round_en) begin
                cap_shift.push_back(int'(key_shift));
                cap_round.push_back(int'(round));
                last_pulse = c;
            end
            if (busy && S != 3'd3) busy_n++;
            if (done) done_at = c;
            if (toggle && c == 6) mode = ~mode;
        end
        chk("run_completes", int'(done_at >= 0), 1);
    endtask

    task automatic check_run(input string tag, input bit dec);
        int sum = 0;
        chk({tag, "_pulses"}, cap_shift.size(), 16);
        for (int i = 0; i < 16 && i < cap_shift.size(); i++) begin
            chk({tag, "_round"}, cap_round[i], i + 1);
            chk({tag, "_shift"}, cap_shift[i], dec ? dec_tbl[i] : enc_tbl[i]);
            sum += cap_shift[i];
        end
        chk({tag, "_sum"}, sum, dec ? 27 : 28);
        chk({tag, "_busy_cycles"}, busy_n, 18);
        chk({tag, "_done_delay"}, done_at - last_pulse, 2);
    endtask

    initial begin
        int l0, f0, msum, dsum;
        rst = 0; start = 1; clear = 1; mode = 0; data_ready = 1; key_ready = 1;

        msum = 0; dsum = 0;
        for (int r = 1; r <= 16; r++) begin
            msum += shift_of(r, 0);
            dsum += shift_of(r, 1);
        end
        chk("model_enc_sum", msum, 28);
        chk("model_dec_sum", dsum, 27);

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_S", int'(S), 0);
        chk("reset_round", int'(round), 0);
        chk("reset_err", int'(err), 0);
        chk("reset_busy_done", int'({busy, done, key_dir}), 0);
        @(posedge clk); #1 rst = 1;

        // Start with key not ready: error, no load.
        key_ready = 0;
        l0 = load_cnt;
        press_start();
        repeat (2) @(posedge clk); #1;
        chk("notready_err", int'(err), 1);
        chk("notready_S", int'(S), 0);
        chk("notready_loads", load_cnt - l0, 0);

        // Encrypt run.
        key_ready = 1; mode = 0;
        press_start();
        capture_run(0);
        check_run("enc", 0);
        chk("enc_err_cleared", int'(err), 0);
        chk("enc_dir", int'(key_dir), 0);

        // Decrypt run restarted from DONE, mode toggled mid-run.
        mode = 1;
        press_start();
        capture_run(1);
        check_run("dec", 1);
        chk("dec_dir_latched", int'(key_dir), 1);

        // Abort mid-run.
        step_delay = 2;
        press_start();
        for (int c = 0; c < 2000 && round != 5'd7; c++) @(negedge clk);
        chk("reach_round7", int'(round), 7);
        f0 = final_cnt;
        @(posedge clk); #1 clear = 0;
        @(posedge clk); #1 clear = 1;
        @(negedge clk);
        chk("clear_S", int'(S), 0);
        chk("clear_round", int'(round), 0);
        chk("clear_busy", int'(busy), 0);
        repeat (30) @(posedge clk); #1;
        chk("clear_no_final", final_cnt - f0, 0);

        // Start held low: exactly one run.
        step_delay = 1;
        l0 = load_cnt;
        @(posedge clk); #1 start = 0;
        for (int c = 0; c < 400 && !done; c++) @(negedge clk);
        repeat (40) @(posedge clk); #1;
        chk("held_done", int'(done), 1);
        start = 1;
        repeat (3) @(posedge clk); #1;
        chk("held_single_load", load_cnt - l0, 1);
        chk("held_done_after_release", int'(done), 1);
        press_start();
        @(posedge clk);
        for (int c = 0; c < 400 && !done; c++) @(negedge clk);
        @(posedge clk); #1;
        chk("repress_loads", load_cnt - l0, 2);

        // Randomised traffic against the model.
        step_noise = 1;
        for (int c = 0; c < 3000; c++) begin
            @(posedge clk); #1;
            start      = ($urandom_range(0, 5) != 0);
            clear      = ($urandom_range(0, 63) != 0);
            data_ready = ($urandom_range(0, 9) != 0);
            key_ready  = ($urandom_range(0, 9) != 0);
            mode       = 1'($urandom_range(0, 1));
        end
        clear = 1; start = 1; data_ready = 1; key_ready = 1;
        step_noise = 0;
        press_start();
        repeat (4) @(posedge clk);

        // Asynchronous reset mid-run.
        #3 rst = 0;
        #1;
        chk("async_reset_S", int'(S), 0);
        chk("async_reset_round", int'(round), 0);
        @(posedge clk); #1 rst = 1;
        repeat (2) @(posedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/des_round_controller.md
Name: des_round_controller

Overview:
Sequencing FSM for the iterative DES datapath. Once the 64-bit data and key entry blocks both report 16 hex digits entered, a start button press walks the datapath through a fixed sequence: load/initial permutation, 16 round steps, then final permutation.
It drives per-round key-schedule shift controls for encrypt or decrypt, then holds done for display. All button inputs are active-low, matching the board pushbuttons.

Parameters:
NUM_ROUNDS, 16, number of Feistel rounds sequenced; the round counter is 5 bits wide.

Ports:
clk  in  1  system clock
rst  in  1  asynchronous active-low reset
start  in  1  active-low start button; only a falling edge is acted on
clear  in  1  active-low abort; returns to IDLE from any state
step  in  1  active-low single-step button; used only with ROUND_STEP_EN
mode  in  1  0 = encrypt, 1 = decrypt; sampled in LOAD
data_ready  in  1  data entry block has 16 digits entered
key_ready  in  1  key entry block has 16 digits entered
dp_load  out  1  datapath: apply IP to data, PC-1 to key
dp_round_en  out  1  datapath: execute one round this cycle
dp_final  out  1  datapath: swap halves and apply IP^-1, register output
key_shift  out  2  rotate amount for C/D halves this round (0, 1 or 2)
key_dir  out  1  rotate direction: 0 = left (encrypt), 1 = right (decrypt)
round  out  5  current round number, 1..16; 0 when idle
busy  out  1  high in LOAD, ROUND, ROUND_WAIT and FINAL
done  out  1  result valid; held high in DONE
err  out  1  sticky flag: start pressed while not ready
S  out  3  current state, exported for LED debug

Behaviour:
- Reset (rst low, asynchronous): S = IDLE, round = 0, mode_q = 0, err = 0, start_q = 1, step_q = 1.
- All dp_* outputs, busy and done are Moore decodes of S. key_shift and key_dir decode from round and mode_q.
- Edge detect: start_fall = start_q & !start; start_q <= start every cycle. step uses the same scheme.
- State encoding: IDLE = 0, LOAD = 1, ROUND = 2, ROUND_WAIT = 3, FINAL = 4, DONE = 5. Any other value goes to IDLE.
- IDLE:
  - If start_fall and data_ready and key_ready: go to LOAD, clear err.
  - If start_fall and either ready flag is low: set err, stay in IDLE.
- LOAD (1 cycle): dp_load = 1, mode_q <= mode, round <= 1, go to ROUND.
- ROUND: dp_round_en = 1.
  - If round == NUM_ROUNDS: go to FINAL.
  - Otherwise round <= round + 1 and stay in ROUND.
- FINAL (1 cycle): dp_final = 1, go to DONE.
- DONE: done = 1, round holds 16.
  - start_fall with both ready flags: go to LOAD (restart).
  - start_fall without both ready flags: set err, stay in DONE.
- Latency: busy is high for exactly 18 cycles (LOAD 1, ROUND 16, FINAL 1). done rises on the next edge.
- Key schedule, encrypt (key_dir = 0): shift 1 in rounds 1, 2, 9 and 16; shift 2 in all other rounds.
- Key schedule, decrypt (key_dir = 1): shift 0 in round 1; shift 1 in rounds 2, 9 and 16; shift 2 in all other rounds.
- key_shift = 0 whenever S is not ROUND.
- Cumulative rotation over 16 rounds: 28 (encrypt) or 27 (decrypt).
- Priority: clear low beats everything, from any state including mid-round. On clear: S = IDLE, round = 0, err = 0, and the datapath is never strobed that cycle.
- mode changes while busy are ignored, because mode_q is latched only in LOAD.
- start held low through the whole run does not cause a restart, because only falling edges are acted on.
- Losing data_ready or key_ready while busy does not abort the run.

Optional Feature:
ROUND_STEP_EN:
- Defined: ROUND is followed by ROUND_WAIT instead of directly by the next ROUND.
  - ROUND lasts 1 cycle (one dp_round_en pulse), then go to ROUND_WAIT with dp_round_en = 0.
  - In ROUND_WAIT, a step falling edge increments round and returns to ROUND.
  - After round 16's ROUND cycle the FSM goes straight to FINAL.
  - busy stays high throughout.
- Undefined: ROUND_WAIT is unreachable, the step input is ignored, and timing is exactly as above.

Decomposition:
- Package des_ctrl_pkg holds:
  - state encoding constants;
  - the 16-entry encrypt shift table (2 bits per entry);
  - the NUM_ROUNDS default.
- One sub-module, btn_fall_detect (1-bit registered falling-edge detector, reset to 1), instanced for start and step.

Test Plan:
- Reset, both ready flags high, mode = 0, start pulsed low: LOAD 1 cycle; dp_round_en 16 cycles with round 1..16; key_shift sequence 1,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1 (sum 28); FINAL; done high; busy high for 18 cycles.
- Same run with mode = 1: key_dir = 1; key_shift 0,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1 (sum 27). Toggle mode mid-run: sequence unchanged.
- key_ready = 0, start pulsed: err = 1, S stays IDLE, no dp_load. Then key_ready = 1 and start pulsed: err = 0, run proceeds.
- clear pulsed low at round 7: next cycle S = IDLE, round = 0, busy = 0; no dp_final ever asserted.
- start held low for 40 cycles: exactly one run; done stays high and no second LOAD until start is released and pressed again.
- With ROUND_STEP_EN: after each dp_round_en pulse the FSM waits in ROUND_WAIT for 100 cycles with no step; 16 step presses complete the run and done rises 2 cycles after the 16th round pulse.
